// File: rtl/dcache_controller.sv
// Blocking dcache controller: hit service, dirty write-back, line refill and replay.
// Optional DCACHE_PERF_CNT_EN adds saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module dcache_controller #(
    parameter int TAG_W  = 23,
    parameter int IDX_W  = 4,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic [IDX_W-1:0]  sram_addr_o,
    output logic [TAG_W+1:0]  sram_tag_o,
    output logic [LINE_W-1:0] sram_data_o,
    output logic              sram_enable_o,
    output logic              sram_write_o,
    input  logic [TAG_W+1:0]  sram_tag_i,
    input  logic [LINE_W-1:0] sram_data_i,
    input  logic              sram_hit_i,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, READMISS, READMISSOK} state_t;

    state_t            state;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [LINE_W-1:0] refill_line;
    logic [LINE_W-1:0] merged_line;

    logic              req;
    logic              hit_now;
    logic              miss_now;
    logic              victim_dirty;
    logic [TAG_W-1:0]  addr_tag;
    logic [IDX_W-1:0]  addr_idx;
    logic [2:0]        word_sel;
    logic [7:0]        word_base;
    logic [1:0]        unused_byte_sel;

    assign req             = cpu_MemRead_i | cpu_MemWrite_i;
    assign addr_tag        = cpu_addr_i[31:32-TAG_W];
    assign addr_idx        = cpu_addr_i[5+IDX_W-1:5];
    assign word_sel        = cpu_addr_i[4:2];
    assign word_base       = {word_sel, 5'b0};
    assign unused_byte_sel = cpu_addr_i[1:0];
    assign hit_now         = (state == IDLE) && req && sram_hit_i;
    assign miss_now        = (state == IDLE) && req && !sram_hit_i;
    assign victim_dirty    = sram_tag_i[TAG_W+1] & sram_tag_i[TAG_W];
    assign sram_addr_o     = addr_idx;

    // Hit and replay paths are combinational so a hit costs no stall cycle.
    always_comb begin
        merged_line = sram_data_i;
        merged_line[word_base +: 32] = cpu_data_i;
        cpu_data_o    = '0;
        cpu_stall_o   = 1'b0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_tag_o    = '0;
        sram_data_o   = '0;
        case (state)
            IDLE: begin
                sram_enable_o = req;
                cpu_stall_o   = miss_now;
                if (hit_now) begin
                    if (cpu_MemWrite_i) begin
                        sram_write_o = 1'b1;
                        sram_tag_o   = {2'b11, addr_tag};
                        sram_data_o  = merged_line;
                    end else begin
                        cpu_data_o = sram_data_i[word_base +: 32];
                    end
                end
            end
            READMISSOK: begin
                cpu_stall_o   = 1'b1;
                sram_enable_o = 1'b1;
                sram_write_o  = 1'b1;
                sram_tag_o    = {2'b10, req_tag};
                sram_data_o   = refill_line;
            end
            default: cpu_stall_o = 1'b1;
        endcase
    end

    // mem_enable_o/mem_write_o pulse only in the cycle a state is entered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            req_tag      <= '0;
            req_idx      <= '0;
            refill_line  <= '0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
        end else begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_now) begin
                        req_tag      <= addr_tag;
                        req_idx      <= addr_idx;
                        mem_enable_o <= 1'b1;
                        if (victim_dirty) begin
                            state       <= WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {sram_tag_i[TAG_W-1:0], addr_idx, 5'b0};
                            mem_data_o  <= sram_data_i;
                        end else begin
                            state      <= READMISS;
                            mem_addr_o <= {addr_tag, addr_idx, 5'b0};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state        <= READMISS;
                        mem_enable_o <= 1'b1;
                        mem_addr_o   <= {req_tag, req_idx, 5'b0};
                    end
                end
                READMISS: begin
                    if (mem_ack_i) begin
                        refill_line <= mem_data_i;
                        state       <= READMISSOK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    // The IDLE cycle right after a refill is the replay and is not a fresh hit.
    logic replay;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            replay     <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            replay <= (state == READMISSOK);
            if (hit_now && !replay && hit_cnt_o != 32'hFFFF_FFFF)
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (miss_now && miss_cnt_o != 32'hFFFF_FFFF)
                miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: hits, clean/dirty misses, reset mid-refill.
// Memory requests are checked in order against an expected queue.
module tb_dcache_controller;

    logic         clk;
    logic         rst;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         cpu_rd;
    logic         cpu_wr;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic [3:0]   sram_addr;
    logic [24:0]  sram_tag_out;
    logic [255:0] sram_data_out;
    logic         sram_enable;
    logic         sram_write;
    logic [24:0]  sram_tag_in;
    logic [255:0] sram_data_in;
    logic         sram_hit;
    logic [31:0]  mem_addr;
    logic [255:0] mem_data_out;
    logic         mem_enable;
    logic         mem_write;
    logic [255:0] mem_data_in;
    logic         mem_ack;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] exp_q[$];

    dcache_controller dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cpu_addr_i     (cpu_addr),
        .cpu_data_i     (cpu_wdata),
        .cpu_MemRead_i  (cpu_rd),
        .cpu_MemWrite_i (cpu_wr),
        .cpu_data_o     (cpu_rdata),
        .cpu_stall_o    (cpu_stall),
        .sram_addr_o    (sram_addr),
        .sram_tag_o     (sram_tag_out),
        .sram_data_o    (sram_data_out),
        .sram_enable_o  (sram_enable),
        .sram_write_o   (sram_write),
        .sram_tag_i     (sram_tag_in),
        .sram_data_i    (sram_data_in),
        .sram_hit_i     (sram_hit),
        .mem_addr_o     (mem_addr),
        .mem_data_o     (mem_data_out),
        .mem_enable_o   (mem_enable),
        .mem_write_o    (mem_write),
        .mem_data_i     (mem_data_in),
        .mem_ack_i      (mem_ack)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt_o      (hit_cnt),
        .miss_cnt_o     (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every memory request pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && mem_enable) begin
            check("mem_req_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0)
                check("mem_req_order", {mem_write, mem_addr}, exp_q.pop_front());
        end
    end

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
        return l;
    endfunction

    logic [255:0] hit_line, refill1, refill2, victim, exp_line;

    initial begin
        rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        sram_tag_in = '0; sram_data_in = '0; sram_hit = 1'b0;
        mem_data_in = '0; mem_ack = 1'b0;
        hit_line = make_line(32'h1000_0000);
        hit_line[127:96] = 32'hDEAD_BEEF;
        refill1 = make_line(32'hA0A0_0000);
        refill2 = make_line(32'hB0B0_0000);
        victim  = make_line(32'h5555_0000);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", cpu_stall, 1'b0);
        check("rst_mem_en", mem_enable, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_data", mem_data_out, 256'h0);
        check("rst_cpu_data", cpu_rdata, 32'h0);
        check("rst_sram_we", sram_write, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Read hit
        @(negedge clk);
        cpu_addr = 32'h0000_000C; cpu_rd = 1'b1; sram_hit = 1'b1;
        sram_data_in = hit_line; sram_tag_in = {2'b10, 23'h0};
        #1;
        check("rd_hit_data", cpu_rdata, 32'hDEAD_BEEF);
        check("rd_hit_stall", cpu_stall, 1'b0);
        check("rd_hit_sram_en", sram_enable, 1'b1);
        check("rd_hit_no_we", sram_write, 1'b0);
        @(posedge clk); #1;
        check("rd_hit_stall_after", cpu_stall, 1'b0);
        check("rd_hit_no_mem", mem_enable, 1'b0);

        // Write hit
        @(negedge clk);
        cpu_addr = 32'h0000_0024; cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_wdata = 32'h1234_5678;
        #1;
        exp_line = hit_line;
        exp_line[63:32] = 32'h1234_5678;
        check("wr_hit_we", sram_write, 1'b1);
        check("wr_hit_idx", sram_addr, 4'h1);
        check("wr_hit_data", sram_data_out, exp_line);
        check("wr_hit_tag", sram_tag_out, {2'b11, 23'h0});
        check("wr_hit_stall", cpu_stall, 1'b0);

        // Both request bits: store wins
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0008; cpu_wdata = 32'h0BAD_F00D;
        #1;
        exp_line = hit_line;
        exp_line[95:64] = 32'h0BAD_F00D;
        check("prio_we", sram_write, 1'b1);
        check("prio_data", sram_data_out, exp_line);

        // Clean miss (dirty bit set but invalid: no write-back)
        @(negedge clk);
        cpu_addr = 32'h0000_0400; cpu_rd = 1'b1; cpu_wr = 1'b0; sram_hit = 1'b0;
        sram_tag_in = {2'b01, 23'h7}; sram_data_in = victim;
        exp_q.push_back({1'b0, 32'h0000_0400});
        #1;
        check("cmiss_stall", cpu_stall, 1'b1);
        check("cmiss_idle_no_mem", mem_enable, 1'b0);
        @(posedge clk); #1;
        check("cmiss_req_en", mem_enable, 1'b1);
        check("cmiss_req_wr", mem_write, 1'b0);
        check("cmiss_req_addr", mem_addr, 32'h0000_0400);
        @(negedge clk);
        sram_tag_in = {2'b11, 23'h1F}; sram_data_in = '0;
        repeat (9) @(negedge clk);
        check("cmiss_wait_stall", cpu_stall, 1'b1);
        check("cmiss_pulse_once", mem_enable, 1'b0);
        mem_ack = 1'b1; mem_data_in = refill1;
        @(negedge clk);
        mem_ack = 1'b0; mem_data_in = '0;
        #1;
        check("cmiss_fill_we", sram_write, 1'b1);
        check("cmiss_fill_en", sram_enable, 1'b1);
        check("cmiss_fill_tag", sram_tag_out, {2'b10, 23'h2});
        check("cmiss_fill_data", sram_data_out, refill1);
        check("cmiss_fill_stall", cpu_stall, 1'b1);
        @(negedge clk);
        sram_hit = 1'b1; sram_data_in = refill1; sram_tag_in = {2'b10, 23'h2};
        #1;
        check("cmiss_replay_stall", cpu_stall, 1'b0);
        check("cmiss_replay_data", cpu_rdata, 32'hA0A0_0000);

        // Dirty store miss: write-back, refill, merged replay
        @(negedge clk);
        cpu_addr = 32'h0000_0608; cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_wdata = 32'hCAFE_F00D;
        sram_hit = 1'b0; sram_tag_in = {2'b11, 23'h5}; sram_data_in = victim;
        exp_q.push_back({1'b1, 32'h0000_0A00});
        exp_q.push_back({1'b0, 32'h0000_0600});
        #1;
        check("dmiss_stall", cpu_stall, 1'b1);
        @(posedge clk); #1;
        check("dmiss_wb_en", mem_enable, 1'b1);
        check("dmiss_wb_wr", mem_write, 1'b1);
        check("dmiss_wb_addr", mem_addr, 32'h0000_0A00);
        check("dmiss_wb_data", mem_data_out, victim);
        @(negedge clk);
        sram_tag_in = '0; sram_data_in = '0;
        repeat (2) @(negedge clk);
        mem_ack = 1'b1; mem_data_in = make_line(32'hFFFF_0000);
        @(posedge clk); #1;
        check("dmiss_rd_en", mem_enable, 1'b1);
        check("dmiss_rd_wr", mem_write, 1'b0);
        check("dmiss_rd_addr", mem_addr, 32'h0000_0600);
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        mem_ack = 1'b1; mem_data_in = refill2;
        @(negedge clk);
        mem_ack = 1'b0; mem_data_in = '0;
        #1;
        check("dmiss_fill_tag", sram_tag_out, {2'b10, 23'h3});
        check("dmiss_fill_data", sram_data_out, refill2);
        @(negedge clk);
        sram_hit = 1'b1; sram_data_in = refill2; sram_tag_in = {2'b10, 23'h3};
        #1;
        exp_line = refill2;
        exp_line[95:64] = 32'hCAFE_F00D;
        check("dmiss_replay_stall", cpu_stall, 1'b0);
        check("dmiss_replay_we", sram_write, 1'b1);
        check("dmiss_replay_data", sram_data_out, exp_line);
        check("dmiss_replay_tag", sram_tag_out, {2'b11, 23'h3});

`ifdef DCACHE_PERF_CNT_EN
        @(negedge clk);
        cpu_wr = 1'b0; sram_hit = 1'b0;
        #1;
        check("perf_hits", hit_cnt, 32'd3);
        check("perf_misses", miss_cnt, 32'd2);
`endif

        // Reset while waiting for the refill; a late ack must be dropped
        @(negedge clk);
        cpu_addr = 32'h0000_0800; cpu_rd = 1'b1; cpu_wr = 1'b0; sram_hit = 1'b0;
        sram_tag_in = '0; sram_data_in = '0;
        exp_q.push_back({1'b0, 32'h0000_0800});
        repeat (2) @(negedge clk);
        rst = 1'b1; cpu_rd = 1'b0;
        #1;
        check("rstmid_stall", cpu_stall, 1'b0);
        check("rstmid_mem_en", mem_enable, 1'b0);
        check("rstmid_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        mem_ack = 1'b1; mem_data_in = refill1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("late_ack_no_we", sram_write, 1'b0);
        check("late_ack_stall", cpu_stall, 1'b0);
        check("late_ack_no_mem", mem_enable, 1'b0);
        mem_ack = 1'b0;
`ifdef DCACHE_PERF_CNT_EN
        check("perf_rst_hits", hit_cnt, 32'd0);
`endif
        @(negedge clk);
        check("mem_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
